// File: rtl/grs_round_pipe.sv
// Two-stage GRS rounding pipeline: capture truncated field plus guard/round/sticky, then apply the increment.
// Optional macro GRS_ROUND_PIPE_INEXACT_EN builds the inexact status register; otherwise out_inexact is 0.
module grs_round_pipe #(
  parameter int INPUT_WIDTH  = 28,
  parameter int OUTPUT_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  in_value,
  input  logic                    in_sign,
  input  logic [2:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] out_value,
  output logic                    out_sign,
  output logic                    out_carry,
  output logic                    out_inexact
);
  localparam int SHIFT = INPUT_WIDTH - OUTPUT_WIDTH;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RPI = 3'd2, RNI = 3'd3, RNA = 3'd4;

  typedef struct packed {
    logic [OUTPUT_WIDTH-1:0] t;
    logic                    g;
    logic                    r;
    logic                    s;
    logic                    sign;
    logic [2:0]              mode;
  } s1_t;

  logic [OUTPUT_WIDTH-1:0] t_in;
  logic g_in, r_in, s_in;

  generate
    if (SHIFT >= 1) begin : g_narrow
      assign t_in = in_value[INPUT_WIDTH-1:SHIFT];
      assign g_in = in_value[SHIFT-1];
      if (SHIFT >= 2) begin : g_r
        assign r_in = in_value[SHIFT-2];
      end else begin : g_nr
        assign r_in = 1'b0;
      end
      if (SHIFT >= 3) begin : g_s
        assign s_in = |in_value[SHIFT-3:0];
      end else begin : g_ns
        assign s_in = 1'b0;
      end
    end else if (SHIFT == 0) begin : g_same
      assign t_in = in_value;
      assign g_in = 1'b0;
      assign r_in = 1'b0;
      assign s_in = 1'b0;
    end else begin : g_wide
      // Widening is exact: zero-fill below the input.
      assign t_in = {in_value, {(-SHIFT){1'b0}}};
      assign g_in = 1'b0;
      assign r_in = 1'b0;
      assign s_in = 1'b0;
    end
  endgenerate

  logic s1_valid, s1_load, s2_load;
  s1_t  s1;

  assign s2_load  = !out_valid | out_ready;
  assign s1_load  = !s1_valid | s2_load;
  assign in_ready = s1_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1       <= '0;
    end else if (s1_load) begin
      s1_valid <= in_valid;
      if (in_valid) s1 <= '{t: t_in, g: g_in, r: r_in, s: s_in, sign: in_sign, mode: in_mode};
    end
  end

  logic                  x, inc;
  logic [OUTPUT_WIDTH:0] sum;

  assign x = s1.g | s1.r | s1.s;

  always_comb begin
    inc = 1'b0;
    case (s1.mode)
      RNE:     inc = s1.g & (s1.r | s1.s | s1.t[0]);
      RTZ:     inc = 1'b0;
      RPI:     inc = !s1.sign & x;
      RNI:     inc = s1.sign & x;
      RNA:     inc = s1.g;
      default: inc = 1'b0;
    endcase
  end

  assign sum = {1'b0, s1.t} + {{OUTPUT_WIDTH{1'b0}}, inc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_value <= '0;
      out_sign  <= 1'b0;
      out_carry <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_value <= sum[OUTPUT_WIDTH-1:0];
        out_carry <= sum[OUTPUT_WIDTH];
        out_sign  <= s1.sign;
      end
    end
  end

`ifdef GRS_ROUND_PIPE_INEXACT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    out_inexact <= 1'b0;
    else if (s2_load && s1_valid)  out_inexact <= x;
  end
`else
  assign out_inexact = 1'b0;
`endif

endmodule

// File: tb/tb_grs_round_pipe.sv
// Directed bench for grs_round_pipe: vector table, backpressure, mid-stream reset, and width sweeps.
module tb_grs_round_pipe;
  localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RPI = 3'd2, RNI = 3'd3, RNA = 3'd4;
`ifdef GRS_ROUND_PIPE_INEXACT_EN
  localparam bit INX_EN = 1'b1;
`else
  localparam bit INX_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_sign = 1'b0, out_ready = 1'b1;
  logic [27:0] in_value = '0;
  logic [2:0]  in_mode = '0;
  logic        in_ready, out_valid, out_sign, out_carry, out_inexact;
  logic [23:0] out_value;
  logic        r28_in_ready, r28_out_valid, r28_out_sign, r28_out_carry, r28_out_inexact;
  logic [27:0] r28_out_value;
  logic        r30_in_ready, r30_out_valid, r30_out_sign, r30_out_carry, r30_out_inexact;
  logic [29:0] r30_out_value;

  always #5 clk = ~clk;

  grs_round_pipe #(.INPUT_WIDTH(28), .OUTPUT_WIDTH(24)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_value(in_value),
    .in_sign(in_sign), .in_mode(in_mode), .out_valid(out_valid), .out_ready(out_ready),
    .out_value(out_value), .out_sign(out_sign), .out_carry(out_carry), .out_inexact(out_inexact));

  grs_round_pipe #(.INPUT_WIDTH(28), .OUTPUT_WIDTH(28)) dut28 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r28_in_ready), .in_value(in_value),
    .in_sign(in_sign), .in_mode(in_mode), .out_valid(r28_out_valid), .out_ready(out_ready),
    .out_value(r28_out_value), .out_sign(r28_out_sign), .out_carry(r28_out_carry),
    .out_inexact(r28_out_inexact));

  grs_round_pipe #(.INPUT_WIDTH(28), .OUTPUT_WIDTH(30)) dut30 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(r30_in_ready), .in_value(in_value),
    .in_sign(in_sign), .in_mode(in_mode), .out_valid(r30_out_valid), .out_ready(out_ready),
    .out_value(r30_out_value), .out_sign(r30_out_sign), .out_carry(r30_out_carry),
    .out_inexact(r30_out_inexact));

  typedef struct {
    logic [27:0] value;
    logic        sign;
    logic [2:0]  mode;
    logic [23:0] exp_value;
    logic        exp_carry;
    logic        exp_x;
  } vec_t;

  int n_chk = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Present one operand into an empty pipe; result must appear after the second edge.
  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_value  = v.value;
    in_sign   = v.sign;
    in_mode   = v.mode;
    check({tag, ".in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check({tag, ".early_valid"}, 32'(out_valid), 32'd0);
    @(negedge clk);
    check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
    check({tag, ".value"}, 32'(out_value), 32'(v.exp_value));
    check({tag, ".carry"}, 32'(out_carry), 32'(v.exp_carry));
    check({tag, ".sign"}, 32'(out_sign), 32'(v.sign));
    check({tag, ".inexact"}, 32'(out_inexact), 32'(v.exp_x & INX_EN));
    check({tag, ".w28.value"}, 32'(r28_out_value), 32'(v.value));
    check({tag, ".w28.cx"}, {30'd0, r28_out_carry, r28_out_inexact}, 32'd0);
    check({tag, ".w30.value"}, 32'(r30_out_value), {2'b00, v.value, 2'b00});
    check({tag, ".w30.cx"}, {30'd0, r30_out_carry, r30_out_inexact}, 32'd0);
    check({tag, ".w30.valid"}, 32'(r30_out_valid & r28_out_valid), 32'd1);
  endtask

  vec_t vecs[17];
  logic [27:0] bp_in[4];
  logic [23:0] bp_exp[4];

  initial begin
    int sent, recv, first_rx, last_rx, cyc;
    logic fire_in, fire_out;
    logic [23:0] held;

    vecs[0]  = '{28'h0000018, 1'b0, RNE,  24'h000002, 1'b0, 1'b1};
    vecs[1]  = '{28'h0000008, 1'b0, RNE,  24'h000000, 1'b0, 1'b1};
    vecs[2]  = '{28'hFFFFFFF, 1'b0, RNA,  24'h000000, 1'b1, 1'b1};
    vecs[3]  = '{28'hFFFFFFF, 1'b0, RTZ,  24'hFFFFFF, 1'b0, 1'b1};
    vecs[4]  = '{28'h0000011, 1'b1, RPI,  24'h000001, 1'b0, 1'b1};
    vecs[5]  = '{28'h0000011, 1'b1, RNI,  24'h000002, 1'b0, 1'b1};
    vecs[6]  = '{28'h0000011, 1'b0, RPI,  24'h000002, 1'b0, 1'b1};
    vecs[7]  = '{28'h0000011, 1'b0, 3'd7, 24'h000001, 1'b0, 1'b1};
    vecs[8]  = '{28'h0000020, 1'b0, RNE,  24'h000002, 1'b0, 1'b0};
    vecs[9]  = '{28'h0000020, 1'b1, RNI,  24'h000002, 1'b0, 1'b0};
    vecs[10] = '{28'h0000020, 1'b0, RNA,  24'h000002, 1'b0, 1'b0};
    vecs[11] = '{28'h0000028, 1'b0, RNE,  24'h000002, 1'b0, 1'b1};
    vecs[12] = '{28'h000002C, 1'b0, RNE,  24'h000003, 1'b0, 1'b1};
    vecs[13] = '{28'h0000014, 1'b0, RNA,  24'h000001, 1'b0, 1'b1};
    vecs[14] = '{28'hFFFFFF8, 1'b0, RNE,  24'h000000, 1'b1, 1'b1};
    vecs[15] = '{28'h0000011, 1'b1, 3'd5, 24'h000001, 1'b0, 1'b1};
    vecs[16] = '{28'h0000004, 1'b0, RPI,  24'h000001, 1'b0, 1'b1};

    // Reset state
    #12;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.outputs", {5'd0, out_value, out_sign, out_carry, out_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);

    foreach (vecs[i]) run_vec(i, vecs[i]);

    // Backpressure: 4 operands offered while the output is stalled
    for (int k = 0; k < 4; k++) begin
      bp_in[k]  = 28'h1000010 + 28'(k) * 28'h10;
      bp_exp[k] = 24'h100001 + 24'(k);
    end
    sent = 0; recv = 0; first_rx = -1; last_rx = -1; held = '0;
    for (cyc = 0; cyc < 40 && recv < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 6);
      in_valid  = (sent < 4);
      in_value  = bp_in[sent < 4 ? sent : 3];
      in_sign   = 1'b0;
      in_mode   = RTZ;
      #1;
      if (cyc == 5) begin
        check("bp.accepted", 32'(sent), 32'd2);
        check("bp.in_ready_low", 32'(in_ready), 32'd0);
        check("bp.held_valid", 32'(out_valid), 32'd1);
        check("bp.held_value", 32'(out_value), 32'(bp_exp[0]));
      end
      if (cyc > 2 && cyc < 6) check("bp.stable", 32'(out_value), 32'(held));
      held     = out_value;
      fire_in  = in_valid & in_ready;
      fire_out = out_valid & out_ready;
      if (fire_out) begin
        check($sformatf("bp.order%0d", recv), 32'(out_value), 32'(bp_exp[recv]));
        if (first_rx < 0) first_rx = cyc;
        last_rx = cyc;
      end
      @(posedge clk);
      if (fire_in) sent++;
      if (fire_out) recv++;
    end
    check("bp.received", 32'(recv), 32'd4);
    check("bp.throughput", 32'(last_rx - first_rx), 32'd3);
    @(negedge clk);
    in_valid = 1'b0;

    // Reset with two operands in flight
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1;
      in_value = 28'h0000018;
      in_sign  = 1'b1;
      in_mode  = RNE;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("mid.full", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid.out_valid", 32'(out_valid), 32'd0);
    check("mid.outputs", {5'd0, out_value, out_sign, out_carry, out_inexact}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("mid.in_ready", 32'(in_ready), 32'd1);
    check("mid.drained", 32'(out_valid), 32'd0);
    run_vec(99, vecs[12]);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
